// File: rtl/serializer_18_if.sv
// Parallel-in / serial-out handshake bundle for serializer_18.
interface serializer_18_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (output load, d, input ready, sout, sout_valid, done);
  modport slave  (input load, d, output ready, sout, sout_valid, done);
endinterface

// File: rtl/serializer_18.sv
// MSB-first parallel-to-serial converter. State changes on the falling
// edge of ck. A new word may be taken in the last-bit cycle, so frames
// stream back to back with no gap.
module serializer_18 #(
  parameter int WIDTH = 4
) (
  input  logic              ck,
  input  logic              rst,
  serializer_18_if.slave    bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             valid_r;
  logic             done_r;
  logic             ready_r;

  // The shift register drains toward the MSB, so sout is always its top bit
  // and reads 0 whenever the register has been cleared in IDLE.
  assign bus.sout       = sreg[WIDTH-1];
  assign bus.sout_valid = valid_r;
  assign bus.done       = done_r;
  assign bus.ready      = ready_r;

  // FSM with registered flags: ready/done are precomputed one edge ahead,
  // so they are high together only while the last bit is on sout.
  always_ff @(negedge ck) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else if (bus.load && ready_r) begin
      // Accept from IDLE or from the last-bit cycle of a running frame.
      state   <= SHIFT;
      sreg    <= bus.d;
      cnt     <= CW'(WIDTH - 1);
      valid_r <= 1'b1;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        state   <= IDLE;
        sreg    <= '0;
        valid_r <= 1'b0;
        done_r  <= 1'b0;
        ready_r <= 1'b1;
      end else begin
        sreg    <= {sreg[WIDTH-2:0], 1'b0};
        cnt     <= cnt - CW'(1);
        valid_r <= 1'b1;
        done_r  <= (cnt == CW'(1));
        ready_r <= (cnt == CW'(1));
      end
    end
  end
endmodule
